timedelay: RTL and testbench

- Input-persistence delay detector. It measures how long the level input `in` has been continuously high, counted in clock periods.
- Each clock period represents 5 time units. Six outputs report elapsed thresholds of 5, 25, 50, 75, 100 and 125 units.
- Used as a generic timing qualifier, e.g. power-good and reset sequencing, so downstream logic can react at staged delays after a condition asserts.

---
 rtl/timedelay.sv | 66 ++++++
 tb/tb_timedelay.sv | 124 ++++++++++++
 2 files changed

// File: rtl/timedelay.sv
// Input-persistence delay detector: counts clock periods the level input has been
// continuously high and flags six staged thresholds combinationally.
module timedelay #(
  parameter int D5   = 1,
  parameter int D25  = 5,
  parameter int D50  = 10,
  parameter int D75  = 15,
  parameter int D100 = 20,
  parameter int D125 = 25,
  parameter int CW   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic t5,
  output logic t25,
  output logic t50,
  output logic t75,
  output logic t100,
  output logic t125
);

  logic [CW-1:0] r_cnt;
  logic [CW:0]   w_cnt_p1;
  logic [5:0]    w_t;

  function automatic int f_thr(input int k);
    case (k)
      0:       f_thr = D5;
      1:       f_thr = D25;
      2:       f_thr = D50;
      3:       f_thr = D75;
      4:       f_thr = D100;
      default: f_thr = D125;
    endcase
  endfunction

  // Saturates at D125 so the top output stays high indefinitely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!in) begin
      r_cnt <= '0;
    end else if (r_cnt < CW'(D125)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // cnt >= D-1 rewritten as cnt+1 >= D on a widened bus so D=1 needs no special case.
  assign w_cnt_p1 = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_thr
      localparam logic [CW:0] THR = (CW+1)'(f_thr(gi));
      assign w_t[gi] = in & ~rst & (w_cnt_p1 >= THR);
    end
  endgenerate

  assign t5   = w_t[0];
  assign t25  = w_t[1];
  assign t50  = w_t[2];
  assign t75  = w_t[3];
  assign t100 = w_t[4];
  assign t125 = w_t[5];

endmodule

// File: tb/tb_timedelay.sv
// Self-checking bench for timedelay: directed ramp/glitch/reset steps plus random
// stimulus, compared against a run-length model of how long in has been high.
module tb_timedelay;

  logic clk = 1'b0;
  logic rst;
  logic in;
  logic t5, t25, t50, t75, t100, t125;

  int vectors = 0;
  int miscompares = 0;
  int run_len = 0;   // edges at which in was sampled high since last low/reset
  int thr [6] = '{1, 5, 10, 15, 20, 25};

  always #5 clk = ~clk;

  timedelay dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .t5  (t5),
    .t25 (t25),
    .t50 (t50),
    .t75 (t75),
    .t100(t100),
    .t125(t125)
  );

  function automatic logic [5:0] model_t();
    logic [5:0] e;
    e = '0;
    for (int k = 0; k < 6; k++)
      e[k] = in && !rst && ((run_len + 1) >= thr[k]);
    return e;
  endfunction

  task automatic drive(input logic in_v, input logic rst_v);
    in  = in_v;
    rst = rst_v;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [5:0] exp_v);
    logic [5:0] obs;
    obs = {t125, t100, t75, t50, t25, t5};
    vectors++;
    $display("%s in=%0b rst=%0b run=%0d t=%06b exp=%06b", tag, in, rst, run_len, obs, exp_v);
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%06b expected=%06b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst || !in) run_len = 0;
    else            run_len++;
    #1;
  endtask

  task automatic step(input string tag, input logic in_v, input logic rst_v);
    drive(in_v, rst_v);
    check(tag, model_t());
    tick();
  endtask

  initial begin
    // Reset with in low, then idle
    drive(1'b0, 1'b1); check("reset_hold", 6'b000000); tick();
    step("idle", 1'b0, 1'b0);

    // Staged ramp: edge n sampled before its update
    for (int n = 1; n <= 30; n++) begin
      drive(1'b1, 1'b0);
      case (n)
        1:  check("ramp_e1",  6'b000001);
        4:  check("ramp_e4",  6'b000001);
        5:  check("ramp_e5",  6'b000011);
        10: check("ramp_e10", 6'b000111);
        15: check("ramp_e15", 6'b001111);
        20: check("ramp_e20", 6'b011111);
        24: check("ramp_e24", 6'b011111);
        25: check("ramp_e25", 6'b111111);
        default: check("ramp", model_t());
      endcase
      tick();
    end

    // Saturation: 100 further cycles, no wrap
    for (int n = 0; n < 100; n++) begin
      drive(1'b1, 1'b0); check("saturate", 6'b111111); tick();
    end

    // Single-cycle glitch restarts timing
    drive(1'b0, 1'b0); check("glitch_low", 6'b000000); tick();
    for (int n = 1; n <= 6; n++) begin
      drive(1'b1, 1'b0);
      check((n == 5) ? "regain_e5" : "regain", (n >= 5) ? 6'b000011 : 6'b000001);
      tick();
    end

    // Mid-operation reset with in held high
    for (int n = 0; n < 6; n++) step("to_t50", 1'b1, 1'b0);
    drive(1'b1, 1'b0); check("pre_rst", 6'b000111); tick();
    drive(1'b1, 1'b1); check("mid_rst", 6'b000000); tick();
    for (int n = 1; n <= 5; n++) begin
      drive(1'b1, 1'b0);
      check((n == 5) ? "post_rst_e5" : "post_rst", (n == 5) ? 6'b000011 : 6'b000001);
      tick();
    end

    // Random: mostly-high input with occasional drops and resets
    for (int n = 0; n < 400; n++) begin
      logic ri, rr;
      ri = ($urandom_range(0, 19) != 0);
      rr = ($urandom_range(0, 59) == 0);
      step("rand", ri, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
